// File: rtl/button_event_gen.sv
// Debounce and event generation for a bank of active-low push buttons.
// Optional auto-repeat of press_pulse after a long press: define BTN_AUTOREPEAT_EN.

module button_event_fsm #(
    parameter int DEBOUNCE_TICKS = 20,
    parameter int LONG_TICKS     = 1000,
    parameter int REPEAT_TICKS   = 200
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_tick,
    input  logic i_s,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_long
);
    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

    localparam int DW = $clog2(DEBOUNCE_TICKS) + 1;
    localparam int HW = $clog2(LONG_TICKS) + 1;
    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_TICKS - 1);
    localparam logic [HW-1:0] H_LAST = HW'(LONG_TICKS - 1);

    state_t        r_state, w_state;
    logic [DW-1:0] r_dcnt, w_dcnt;
    logic [HW-1:0] r_hcnt, w_hcnt;
    logic          r_long_done, w_long_done;
    logic          r_level, w_level;
    logic          r_press, w_press;
    logic          r_release, w_release;
    logic          r_long, w_long;
`ifdef BTN_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_TICKS) + 1;
    localparam logic [RW-1:0] R_LAST = RW'(REPEAT_TICKS - 1);
    logic [RW-1:0] r_rcnt, w_rcnt;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_dcnt      <= '0;
            r_hcnt      <= '0;
            r_long_done <= 1'b0;
            r_level     <= 1'b0;
            r_press     <= 1'b0;
            r_release   <= 1'b0;
            r_long      <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            r_rcnt      <= '0;
`endif
        end else begin
            r_state     <= w_state;
            r_dcnt      <= w_dcnt;
            r_hcnt      <= w_hcnt;
            r_long_done <= w_long_done;
            r_level     <= w_level;
            r_press     <= w_press;
            r_release   <= w_release;
            r_long      <= w_long;
`ifdef BTN_AUTOREPEAT_EN
            r_rcnt      <= w_rcnt;
`endif
        end
    end

    always_comb begin
        w_state     = r_state;
        w_dcnt      = r_dcnt;
        w_hcnt      = r_hcnt;
        w_long_done = r_long_done;
        w_level     = r_level;
        w_press     = 1'b0;
        w_release   = 1'b0;
        w_long      = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
        w_rcnt      = r_rcnt;
`endif
        case (r_state)
            IDLE: begin
                if (!i_s) begin
                    w_state = PRESS_WAIT;
                    w_dcnt  = '0;
                end
            end
            PRESS_WAIT: begin
                if (i_s) begin
                    w_state = IDLE;
                end else if (i_tick) begin
                    if (r_dcnt == D_LAST) begin
                        w_state     = HELD;
                        w_press     = 1'b1;
                        w_level     = 1'b1;
                        w_hcnt      = '0;
                        w_long_done = 1'b0;
                    end else begin
                        w_dcnt = r_dcnt + DW'(1);
                    end
                end
            end
            HELD: begin
                // A release edge takes priority over the hold tick of the same cycle.
                if (i_s) begin
                    w_state = RELEASE_WAIT;
                    w_dcnt  = '0;
                end else if (i_tick) begin
                    if (r_hcnt != H_LAST) w_hcnt = r_hcnt + HW'(1);
                    if (!r_long_done && (w_hcnt == H_LAST)) begin
                        w_long      = 1'b1;
                        w_long_done = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                        w_rcnt      = '0;
                    end else if (r_long_done) begin
                        if (r_rcnt == R_LAST) begin
                            w_press = 1'b1;
                            w_rcnt  = '0;
                        end else begin
                            w_rcnt = r_rcnt + RW'(1);
                        end
`endif
                    end
                end
            end
            RELEASE_WAIT: begin
                if (!i_s) begin
                    w_state = HELD;
                end else if (i_tick) begin
                    if (r_dcnt == D_LAST) begin
                        w_state   = IDLE;
                        w_release = 1'b1;
                        w_level   = 1'b0;
                    end else begin
                        w_dcnt = r_dcnt + DW'(1);
                    end
                end
            end
            default: w_state = IDLE;
        endcase
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_long    = r_long;
endmodule

module button_event_gen #(
    parameter int NUM_BTN        = 3,
    parameter int TICK_DIV       = 50000,
    parameter int DEBOUNCE_TICKS = 20,
    parameter int LONG_TICKS     = 1000,
    parameter int REPEAT_TICKS   = 200
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NUM_BTN-1:0] i_btn_n,
    output logic [NUM_BTN-1:0] o_btn_level,
    output logic [NUM_BTN-1:0] o_press_pulse,
    output logic [NUM_BTN-1:0] o_release_pulse,
    output logic [NUM_BTN-1:0] o_long_pulse
);
    localparam int PW = $clog2(TICK_DIV) + 1;
    localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

    if (TICK_DIV < 2 || DEBOUNCE_TICKS < 1 || LONG_TICKS <= DEBOUNCE_TICKS || REPEAT_TICKS < 1)
    begin : g_bad_params
        $error("button_event_gen: illegal parameter combination");
    end

    logic [NUM_BTN-1:0] r_sync1, r_sync2;
    logic [PW-1:0]      r_pcnt;
    logic               w_tick;

    // Synchronizer flops idle at 1 so a reset never looks like a press.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
            r_pcnt  <= '0;
        end else begin
            r_sync1 <= i_btn_n;
            r_sync2 <= r_sync1;
            r_pcnt  <= (r_pcnt == P_LAST) ? '0 : r_pcnt + PW'(1);
        end
    end

    assign w_tick = (r_pcnt == P_LAST);

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        button_event_fsm #(
            .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
            .LONG_TICKS     (LONG_TICKS),
            .REPEAT_TICKS   (REPEAT_TICKS)
        ) u_fsm (
            .i_clk     (i_clk),
            .i_rst     (i_rst),
            .i_tick    (w_tick),
            .i_s       (r_sync2[g]),
            .o_level   (o_btn_level[g]),
            .o_press   (o_press_pulse[g]),
            .o_release (o_release_pulse[g]),
            .o_long    (o_long_pulse[g])
        );
    end
endmodule

// File: tb/tb_button_event_gen.sv
// Self-checking bench for button_event_gen: directed scenarios plus random button
// activity, compared every cycle against a debounce-rule model.

module tb_button_event_gen;
    localparam int NB = 3;
    localparam int TD = 4;
    localparam int DB = 3;
    localparam int LT = 10;
    localparam int RT = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NB-1:0] btn_n = '1;
    logic [NB-1:0] btn_level, press_pulse, release_pulse, long_pulse;

    button_event_gen #(
        .NUM_BTN(NB), .TICK_DIV(TD), .DEBOUNCE_TICKS(DB),
        .LONG_TICKS(LT), .REPEAT_TICKS(RT)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_btn_n(btn_n),
        .o_btn_level(btn_level), .o_press_pulse(press_pulse),
        .o_release_pulse(release_pulse), .o_long_pulse(long_pulse)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic check_vec(string nm, logic [NB-1:0] got, logic [NB-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%b exp=%b", nm, cyc, got, exp);
        end
    endtask

    task automatic check_rng(string nm, int got, int lo, int hi);
        checks++;
        if (got < lo || got > hi) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d exp=[%0d..%0d]", nm, cyc, got, lo, hi);
        end
    endtask

    // Model: a change of the synchronized level is accepted once it has been seen
    // continuously different from the accepted level across DB ticks (ticks on the
    // cycle it was first noticed do not count). Hold time counts ticks while the
    // button is settled pressed.
    bit            m_valid = 0;
    int            ncyc;
    logic [NB-1:0] m_sync1, m_sync2, m_lvl, m_ldone;
    int            m_run[NB], m_hold[NB], m_rep[NB];
    logic [NB-1:0] e_press, e_rel, e_long;
    bit            tick, pressed, settled;

    always @(posedge clk) begin
        cyc++;
        e_press = '0; e_rel = '0; e_long = '0;
        if (rst) begin
            m_valid = 1;
            ncyc    = 0;
            m_sync1 = '1; m_sync2 = '1; m_lvl = '0; m_ldone = '0;
            for (int i = 0; i < NB; i++) begin
                m_run[i] = -1; m_hold[i] = 0; m_rep[i] = 0;
            end
        end else begin
            tick = ((ncyc % TD) == TD - 1);
            ncyc++;
            for (int i = 0; i < NB; i++) begin
                pressed    = !m_sync2[i];
                m_sync2[i] = m_sync1[i];
                m_sync1[i] = btn_n[i];
                if (pressed != m_lvl[i]) begin
                    if (m_run[i] < 0) m_run[i] = 0;
                    else if (tick) begin
                        m_run[i]++;
                        if (m_run[i] == DB) begin
                            m_run[i] = -1;
                            m_lvl[i] = pressed;
                            if (pressed) begin
                                e_press[i] = 1'b1; m_hold[i] = 0; m_ldone[i] = 1'b0;
                            end else e_rel[i] = 1'b1;
                        end
                    end
                end else begin
                    settled  = (m_run[i] < 0);
                    m_run[i] = -1;
                    if (m_lvl[i] && settled && tick) begin
                        if (m_hold[i] < LT - 1) m_hold[i]++;
                        if (m_hold[i] == LT - 1 && !m_ldone[i]) begin
                            e_long[i] = 1'b1; m_ldone[i] = 1'b1; m_rep[i] = 0;
                        end
`ifdef BTN_AUTOREPEAT_EN
                        else if (m_ldone[i]) begin
                            m_rep[i]++;
                            if (m_rep[i] == RT) begin e_press[i] = 1'b1; m_rep[i] = 0; end
                        end
`endif
                    end
                end
            end
        end
    end

    // Compare plus event bookkeeping taken from the DUT outputs.
    int            press_cnt[NB], rel_cnt[NB], long_cnt[NB];
    int            last_press[NB], last_rel[NB], last_evt[NB], long_gap[NB], rep_gap[NB];
    logic [NB-1:0] prev_lvl = '0;

    always @(negedge clk) begin
        if (m_valid) begin
            check_vec("btn_level", btn_level, m_lvl);
            check_vec("press_pulse", press_pulse, e_press);
            check_vec("release_pulse", release_pulse, e_rel);
            check_vec("long_pulse", long_pulse, e_long);
            for (int i = 0; i < NB; i++) begin
                if (press_pulse[i] === 1'b1) begin
                    if (prev_lvl[i]) rep_gap[i] = cyc - last_evt[i];
                    press_cnt[i]++; last_press[i] = cyc; last_evt[i] = cyc;
                end
                if (release_pulse[i] === 1'b1) begin rel_cnt[i]++; last_rel[i] = cyc; end
                if (long_pulse[i] === 1'b1) begin
                    long_cnt[i]++; long_gap[i] = cyc - last_press[i]; last_evt[i] = cyc;
                end
            end
            prev_lvl = btn_level;
        end
    end

    int sp[NB], sr[NB], sl[NB];
    task automatic snap();
        for (int i = 0; i < NB; i++) begin
            sp[i] = press_cnt[i]; sr[i] = rel_cnt[i]; sl[i] = long_cnt[i];
        end
    endtask

    initial begin
        int c0;
        int dur[NB];

        // Reset and idle
        rst = 1'b1; btn_n = '1;
        repeat (5) @(negedge clk);
        check_vec("reset_level", btn_level, 3'b000);
        rst = 1'b0;
        snap();
        repeat (200) @(negedge clk);
        for (int i = 0; i < NB; i++) begin
            check_rng("idle_press", press_cnt[i] - sp[i], 0, 0);
            check_rng("idle_release", rel_cnt[i] - sr[i], 0, 0);
            check_rng("idle_long", long_cnt[i] - sl[i], 0, 0);
        end

        // Clean press and release on bit 0
        snap();
        c0 = cyc; btn_n[0] = 1'b0;
        repeat (100) @(negedge clk);
        check_rng("clean_press_count", press_cnt[0] - sp[0], 1, 1);
        check_rng("clean_press_latency", last_press[0] - c0, 10, 16);
        check_vec("clean_level_high", btn_level, 3'b001);
        check_vec("model_level_high", m_lvl, 3'b001);
        c0 = cyc; btn_n[0] = 1'b1;
        repeat (100) @(negedge clk);
        check_rng("clean_release_count", rel_cnt[0] - sr[0], 1, 1);
        check_rng("clean_release_latency", last_rel[0] - c0, 10, 16);
        check_vec("clean_level_low", btn_level, 3'b000);
        for (int i = 1; i < NB; i++) begin
            check_rng("clean_other_press", press_cnt[i] - sp[i], 0, 0);
            check_rng("clean_other_release", rel_cnt[i] - sr[i], 0, 0);
        end

        // Bounce on bit 1
        snap();
        for (int k = 0; k < 40; k++) begin
            if (k % 3 == 0) btn_n[1] = ~btn_n[1];
            @(negedge clk);
        end
        btn_n[1] = 1'b1;
        repeat (50) @(negedge clk);
        check_rng("bounce_press", press_cnt[1] - sp[1], 0, 0);
        check_rng("bounce_release", rel_cnt[1] - sr[1], 0, 0);

        // Long press on bit 2
        snap();
        btn_n[2] = 1'b0;
        repeat (80) @(negedge clk);
        btn_n[2] = 1'b1;
        repeat (60) @(negedge clk);
        check_rng("long_count", long_cnt[2] - sl[2], 1, 1);
        check_rng("long_gap", long_gap[2], 36, 36);
        check_rng("long_release", rel_cnt[2] - sr[2], 1, 1);
`ifdef BTN_AUTOREPEAT_EN
        check_rng("repeat_press_count", press_cnt[2] - sp[2], 4, 5);
        check_rng("repeat_gap", rep_gap[2], 8, 8);
`else
        check_rng("long_press_count", press_cnt[2] - sp[2], 1, 1);
`endif

        // Simultaneous press, then reset mid-hold
        snap();
        btn_n[1:0] = 2'b00;
        repeat (30) @(negedge clk);
        check_rng("simul_press0", press_cnt[0] - sp[0], 1, 1);
        check_rng("simul_press1", press_cnt[1] - sp[1], 1, 1);
        check_rng("simul_same_cycle", last_press[0] - last_press[1], 0, 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_vec("reset_mid_hold_level", btn_level, 3'b000);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check_rng("repress0", press_cnt[0] - sp[0], 2, 2);
        check_rng("repress1", press_cnt[1] - sp[1], 2, 2);
        check_rng("reset_no_release0", rel_cnt[0] - sr[0], 0, 0);
        check_rng("reset_no_release1", rel_cnt[1] - sr[1], 0, 0);
        check_vec("repress_level", btn_level, 3'b011);
        btn_n = '1;
        repeat (40) @(negedge clk);

        // Random activity with occasional reset
        for (int i = 0; i < NB; i++) dur[i] = 0;
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < NB; i++) begin
                if (dur[i] == 0) begin
                    btn_n[i] = ~btn_n[i];
                    dur[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(40, 120))
                                                         : int'($urandom_range(1, 20));
                end else dur[i]--;
            end
            rst = ($urandom_range(0, 599) == 0);
            @(negedge clk);
        end
        rst = 1'b0; btn_n = '1;
        repeat (60) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/button_event_gen.md
# button_event_gen

Debounces and conditions a bank of active-low push buttons into clean, single-cycle event pulses: press, release and long-press. It also provides a stable debounced level per button. It sits between the board button pins and the LED and control logic, producing the edges that downstream toggle logic consumes. This removes the need for raw-pin edge detection anywhere else in the design. Each button is handled by its own independent per-button state machine, and all buttons share one millisecond-scale tick prescaler.

## Interface
- NUM_BTN, 3, number of buttons.
- TICK_DIV, 50000, clk cycles per debounce tick (1 ms at 50 MHz); must be ≥ 2.
- DEBOUNCE_TICKS, 20, consecutive stable ticks required to accept a level change; must be ≥ 1.
- LONG_TICKS, 1000, ticks in HELD before long_pulse; must be greater than DEBOUNCE_TICKS.
- REPEAT_TICKS, 200, auto-repeat period in ticks; only used with BTN_AUTOREPEAT_EN.
- clk  in  1  system clock; everything is on posedge.
- rst  in  1  synchronous, active-high reset.
- btn_n  in  NUM_BTN  raw active-low buttons, asynchronous to clk.
- btn_level  out  NUM_BTN  debounced state, 1 = pressed.
- press_pulse  out  NUM_BTN  one-cycle pulse on an accepted press (and on each repeat).
- release_pulse  out  NUM_BTN  one-cycle pulse on an accepted release.
- long_pulse  out  NUM_BTN  one-cycle pulse once per hold when the hold reaches LONG_TICKS.

## Operation
- **Synchronizer:** each btn_n bit passes through a 2-flop synchronizer. Both flops reset to 1 (released). Only the synchronized value s is used downstream.
- **Prescaler:** the counter runs 0..TICK_DIV-1 and wraps.
  - tick is a one-cycle pulse while the count equals TICK_DIV-1.
  - Reset sets the count to 0, so the first tick occurs on the TICK_DIV-th cycle after rst deasserts.
- **Per-button FSM:** four states, IDLE, PRESS_WAIT, HELD and RELEASE_WAIT. Each button has a debounce counter dcnt, a hold counter hcnt and a long_done flag.
  - **IDLE:**
    - If s==0, go to PRESS_WAIT with dcnt=0.
  - **PRESS_WAIT:**
    - If s==1, return to IDLE. This is a bounce and emits no pulse.
    - Otherwise, on tick with dcnt==DEBOUNCE_TICKS-1, go to HELD. Assert press_pulse, set btn_level=1, hcnt=0 and long_done=0.
    - Otherwise, on tick, increment dcnt.
  - **HELD:**
    - If s==1, go to RELEASE_WAIT with dcnt=0.
    - On tick, hcnt increments and saturates at LONG_TICKS-1.
    - The first tick at which hcnt==LONG_TICKS-1 while long_done==0 asserts long_pulse and sets long_done.
  - **RELEASE_WAIT:**
    - hcnt is frozen in this state.
    - If s==0, return to HELD. The bounce emits no pulse, and hcnt and long_done are kept.
    - On tick with dcnt==DEBOUNCE_TICKS-1, go to IDLE. Assert release_pulse and set btn_level=0.
    - Otherwise, on tick, increment dcnt.
- **Width rules:** counter widths are $clog2 of their maximum value plus 1, and no counter wraps.
- **Simultaneous events:** buttons are fully independent. Any combination of bits may pulse in the same cycle. press_pulse, release_pulse and long_pulse for a single button are never asserted in the same cycle.
- **Reset mid-operation:** every FSM returns to IDLE and all outputs go to 0. No release_pulse is emitted for a button that was held. A button still held after reset is re-debounced and produces a fresh press_pulse.

## Timing
- Reset values: btn_level=0, press_pulse=0, release_pulse=0, long_pulse=0, all FSMs in IDLE, synchronizer flops at 1.
- All outputs are registered.
- Press latency is measured from a btn_n fall held stable to the press_pulse cycle. It lies within [(DEBOUNCE_TICKS-1)*TICK_DIV+2, DEBOUNCE_TICKS*TICK_DIV+4] cycles. Release latency has the same bounds.
- btn_level changes in the same cycle as the corresponding press_pulse or release_pulse.
- long_pulse fires (LONG_TICKS-1) ticks after press_pulse, plus any ticks spent in HELD, with RELEASE_WAIT ticks excluded.
- A bounce shorter than one tick interval is always rejected. A change is accepted only if it stays stable for DEBOUNCE_TICKS consecutive ticks.

## Configuration
- BTN_AUTOREPEAT_EN defined:
  - After long_pulse, while the button stays in HELD, press_pulse re-asserts every REPEAT_TICKS ticks.
  - The repeat counter resets on the long_pulse cycle and on every repeat pulse. It is frozen in RELEASE_WAIT.
- BTN_AUTOREPEAT_EN undefined:
  - Exactly one press_pulse per accepted press.
  - The repeat logic is absent and REPEAT_TICKS is ignored.

## Test plan
Parameters for all scenarios: TICK_DIV=4, DEBOUNCE_TICKS=3, LONG_TICKS=10, REPEAT_TICKS=2.
- **Reset and idle:** assert rst for 5 cycles with btn_n=3'b111 → all outputs 0 and no pulses over 200 cycles.
- **Clean press and release:** drive btn_n[0]=0 for 100 cycles, then 1.
  - Exactly one press_pulse[0], 10–16 cycles after the fall.
  - btn_level[0]=1 until one release_pulse[0], 10–16 cycles after the rise.
  - Bits 1 and 2 stay silent.
- **Bounce:** toggle btn_n[1] every 3 cycles for 40 cycles, then hold it at 1 → no pulses and btn_level[1] stays 0.
- **Long press:** hold btn_n[2]=0 for 80 cycles.
  - One press_pulse[2], then one long_pulse[2] 36 cycles later (9 ticks).
  - With BTN_AUTOREPEAT_EN, press_pulse[2] also repeats every 8 cycles after long_pulse; without it, no further pulses.
- **Simultaneous and reset:** press btn_n[0] and btn_n[1] in the same cycle.
  - Both press_pulse bits assert in the same cycle.
  - Asserting rst mid-hold clears btn_level with no release_pulse.
  - After rst deasserts with the buttons still held, a new press_pulse appears for both bits.
